// File: rtl/baby_pkg.sv
// -----------------------------------------------------------------------------
// baby_pkg
// Shared constants and types for Baby main-store clients.
//   WORD_W        store word width in bits
//   STORE_WORDS   number of store lines
//   STORE_ADDR_W  store line address width, log2(STORE_WORDS)
//   loader_state_t  state encoding of the store loader FSM
// -----------------------------------------------------------------------------
package baby_pkg;

    localparam int WORD_W       = 32;
    localparam int STORE_WORDS  = 32;
    localparam int STORE_ADDR_W = 5;

    typedef enum logic [2:0] {
        LD_START      = 3'd0,
        LD_WRITE      = 3'd1,
        LD_VERIFY_RD  = 3'd2,
        LD_VERIFY_CMP = 3'd3,
        LD_DONE       = 3'd4,
        LD_ERROR      = 3'd5
    } loader_state_t;

endpackage

// File: rtl/baby_store_loader_if.sv
// -----------------------------------------------------------------------------
// baby_store_loader_if
// Main-store access bus between the loader (master) and the store (slave).
//   store_we     write strobe              (master -> slave)
//   store_re     read strobe               (master -> slave)
//   store_addr   store line address        (master -> slave)
//   store_wdata  write data                (master -> slave)
//   store_busy   stall, access accepted only when 0 (slave -> master)
//   store_rdata  read data, one cycle after an accepted read (slave -> master)
// -----------------------------------------------------------------------------
interface baby_store_loader_if
    import baby_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int ADDR_W = STORE_ADDR_W
);

    logic              store_we;
    logic              store_re;
    logic [ADDR_W-1:0] store_addr;
    logic [WIDTH-1:0]  store_wdata;
    logic              store_busy;
    logic [WIDTH-1:0]  store_rdata;

    modport master (
        output store_we, store_re, store_addr, store_wdata,
        input  store_busy, store_rdata
    );

    modport slave (
        input  store_we, store_re, store_addr, store_wdata,
        output store_busy, store_rdata
    );

endinterface

// File: rtl/baby_store_loader.sv
// -----------------------------------------------------------------------------
// baby_store_loader
// Copies the program image into the Baby main store one word per cycle,
// reads every line back to verify it and keeps the CPU stopped until the
// image is confirmed.
//   clk, rst_n   clock (rising edge) and async active-low reset
//   prog         program image, one signed word per store line
//   load_req     reload request, honoured only in DONE or ERROR
//   bus          store access bus (master side)
//   cpu_hold     holds the Baby in stop while high
//   load_done    image written and verified
//   verify_err   readback mismatch seen (held until reload)
//   err_addr     line of the first mismatch
//
// state         | meaning
// --------------+---------------------------------------------------
// LD_START      | idle cycle before a load, cpu held
// LD_WRITE      | writing prog[cnt] to line cnt
// LD_VERIFY_RD  | issuing read of line cnt
// LD_VERIFY_CMP | comparing returned data with prog[cnt]
// LD_DONE       | image verified, cpu released
// LD_ERROR      | mismatch at line cnt, cpu held
// -----------------------------------------------------------------------------
module baby_store_loader
    import baby_pkg::*;
#(
    parameter int WORDS  = STORE_WORDS,
    parameter int WIDTH  = WORD_W,
    parameter int ADDR_W = STORE_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] prog [WORDS],
    input  logic                    load_req,
    baby_store_loader_if.master     bus,
    output logic                    cpu_hold,
    output logic                    load_done,
    output logic                    verify_err,
    output logic [ADDR_W-1:0]       err_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LD_START;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LD_START: begin
                state_d = LD_WRITE;
                cnt_d   = '0;
            end
            LD_WRITE: begin
                if (!bus.store_busy) begin
                    // WORDS is a power of two, so the increment wraps to 0
                    // after the last line.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = LD_VERIFY_RD;
                    end
                end
            end
            LD_VERIFY_RD: begin
                if (!bus.store_busy) begin
                    state_d = LD_VERIFY_CMP;
                end
            end
            LD_VERIFY_CMP: begin
                // Read data returns unconditionally one cycle after an
                // accepted read, so busy plays no part here.
                if (bus.store_rdata != $unsigned(prog[cnt_q])) begin
                    state_d = LD_ERROR;
                end else if (cnt_q == LAST) begin
                    state_d = LD_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = LD_VERIFY_RD;
                end
            end
            LD_DONE, LD_ERROR: begin
                if (load_req) begin
                    state_d = LD_START;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = LD_START;
                cnt_d   = '0;
            end
        endcase
    end

    // cnt holds while in ERROR, so the failing line is recovered from it
    // rather than kept in a separate register.
    always_comb begin
        bus.store_we    = 1'b0;
        bus.store_re    = 1'b0;
        bus.store_addr  = cnt_q;
        bus.store_wdata = $unsigned(prog[cnt_q]);
        cpu_hold        = 1'b1;
        load_done       = 1'b0;
        verify_err      = 1'b0;
        err_addr        = '0;
        case (state_q)
            LD_WRITE:     bus.store_we = 1'b1;
            LD_VERIFY_RD: bus.store_re = 1'b1;
            LD_DONE: begin
                cpu_hold  = 1'b0;
                load_done = 1'b1;
            end
            LD_ERROR: begin
                verify_err = 1'b1;
                err_addr   = cnt_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_baby_store_loader.sv
module tb_baby_store_loader;
    import baby_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic signed [WORD_W-1:0] prog [STORE_WORDS];
    logic                     load_req;
    logic                     cpu_hold, load_done, verify_err;
    logic [STORE_ADDR_W-1:0]  err_addr;

    baby_store_loader_if bus ();

    baby_store_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prog       (prog),
        .load_req   (load_req),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .verify_err (verify_err),
        .err_addr   (err_addr)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ideal store model with optional corruption of one line on write
    logic [WORD_W-1:0] mem [STORE_WORDS];
    logic [4:0]        wr_log [512];
    int                wr_n      = 0;
    int                overlap_n = 0;
    logic              corrupt_en = 1'b0;

    always @(posedge clk) begin
        if (bus.store_we && bus.store_re) overlap_n <= overlap_n + 1;
        if (bus.store_we && !bus.store_busy) begin
            mem[bus.store_addr] <= (corrupt_en && bus.store_addr == 5'd17) ?
                                   (bus.store_wdata ^ 32'h1) : bus.store_wdata;
            wr_log[wr_n[8:0]]   <= bus.store_addr;
            wr_n                <= wr_n + 1;
        end
        if (bus.store_re && !bus.store_busy) bus.store_rdata <= mem[bus.store_addr];
    end

    task automatic wait_done(input int max, input int pulse_at, output int n);
        n = 0;
        while (!load_done && n < max) begin
            load_req = (n == pulse_at);
            @(posedge clk);
            #1;
            n++;
        end
        load_req = 1'b0;
    endtask

    task automatic wait_line(input bit wr, input int line, output bit found);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (wr ? (bus.store_we && bus.store_addr == line[4:0])
                   : (bus.store_re && bus.store_addr == line[4:0]))
                found = 1'b1;
        end
    endtask

    task automatic check_image(input string tag, input int base);
        check($sformatf("%s_wr_count", tag), wr_n - base, 32);
        for (int i = 0; i < STORE_WORDS; i++) begin
            check($sformatf("%s_wr_order[%0d]", tag, i), {27'd0, wr_log[(base + i) % 512]}, i);
            check($sformatf("%s_mem[%0d]", tag, i), mem[i], prog[i]);
        end
    endtask

    task automatic restart();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int   n;
        int   base;
        bit   found;

        rst_n          = 1'b0;
        load_req       = 1'b0;
        bus.store_busy = 1'b0;
        for (int i = 0; i < STORE_WORDS; i++) prog[i] = i * 32'h01010101;
        prog[0] = 32'h5A5A_0000;

        // reset values
        #3;
        check("rst_we",       bus.store_we, 0);
        check("rst_re",       bus.store_re, 0);
        check("rst_addr",     bus.store_addr, 0);
        check("rst_wdata",    bus.store_wdata, 32'h5A5A_0000);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_done",     load_done, 0);
        check("rst_verr",     verify_err, 0);
        check("rst_eaddr",    err_addr, 0);
        prog[0] = 32'h0;

        // 1: plain load, no stalls
        @(negedge clk);
        base  = wr_n;
        rst_n = 1'b1;
        wait_done(200, -1, n);
        check("t1_done_edge", n, 97);
        check("t1_cpu_hold",  cpu_hold, 0);
        check("t1_verr",      verify_err, 0);
        check_image("t1", base);

        // 2: stalls on write of line 5 and read of line 20
        @(negedge clk);
        base = wr_n;
        restart();
        fork
            wait_done(200, -1, n);
            begin
                wait_line(1'b1, 5, found);
                check("t2_found_wr5", found, 1);
                bus.store_busy = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                check("t2_hold_addr", bus.store_addr, 5);
                bus.store_busy = 1'b0;
                wait_line(1'b0, 20, found);
                check("t2_found_rd20", found, 1);
                bus.store_busy = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                bus.store_busy = 1'b0;
            end
        join
        check("t2_done_edge", n, 102);
        check_image("t2", base);

        // 3: line 17 corrupted by the store
        @(negedge clk);
        corrupt_en = 1'b1;
        restart();
        n = 0;
        while (!verify_err && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t3_err_edge", n, 69);
        check("t3_eaddr",    err_addr, 17);
        check("t3_cpu_hold", cpu_hold, 1);
        check("t3_done",     load_done, 0);
        repeat (5) @(posedge clk);
        #1;
        check("t3_verr_sticky",  verify_err, 1);
        check("t3_eaddr_sticky", err_addr, 17);
        check("t3_done_stays",   load_done, 0);
        corrupt_en = 1'b0;
        load_req   = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        check("t3_clr_verr",  verify_err, 0);
        check("t3_clr_eaddr", err_addr, 0);
        check("t3_clr_hold",  cpu_hold, 1);
        base = wr_n;
        wait_done(200, -1, n);
        check("t3_reload_edge", n, 97);
        check_image("t3", base);

        // 4: reset while writing line 12
        @(negedge clk);
        base = wr_n;
        restart();
        wait_line(1'b1, 12, found);
        check("t4_found_wr12", found, 1);
        rst_n = 1'b0;
        #1;
        check("t4_we",       bus.store_we, 0);
        check("t4_re",       bus.store_re, 0);
        check("t4_addr",     bus.store_addr, 0);
        check("t4_wdata",    bus.store_wdata, prog[0]);
        check("t4_cpu_hold", cpu_hold, 1);
        @(posedge clk);
        #1;
        check("t4_partial_writes", wr_n - base, 12);
        @(negedge clk);
        base  = wr_n;
        rst_n = 1'b1;
        wait_done(200, -1, n);
        check("t4_done_edge", n, 97);
        check_image("t4", base);

        // 5: reload from DONE with a new last word, ignored request in WRITE
        prog[31] = 32'hFFFF_FFFF;
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        check("t5_hold_rise", cpu_hold, 1);
        check("t5_done_clr",  load_done, 0);
        base = wr_n;
        wait_done(200, 10, n);
        check("t5_done_edge", n, 97);
        check("t5_mem31",     mem[31], 32'hFFFF_FFFF);
        check_image("t5", base);

        check("no_we_re_overlap", overlap_n, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
